// File: rtl/cic_interp_pkg.sv
// Shared width helpers, saturation and the wide lane-arithmetic type for the
// multi-channel CIC interpolator.
package cic_interp_pkg;

  localparam int MAX_ACC_W = 128;
  typedef logic signed [MAX_ACC_W-1:0] acc_max_t;

  function automatic int acc_width(int in_w, int stages, int max_rate, int delay);
    return in_w + stages * $clog2(max_rate * delay);
  endfunction

  function automatic int rate_width(int max_rate);
    return $clog2(max_rate) + 1;
  endfunction

  function automatic int shift_width(int acc_w);
    return $clog2(acc_w);
  endfunction

  // Clip a wide signed value into the range of a w-bit signed number.
  function automatic acc_max_t sat(acc_max_t a, int w);
    acc_max_t hi, lo;
    hi = (acc_max_t'(1) <<< (w - 1)) - acc_max_t'(1);
    lo = ~hi;
    if (a > hi) return hi;
    else if (a < lo) return lo;
    else return a;
  endfunction

endpackage

// File: rtl/cic_interp_mc_if.sv
// Config + input/output handshake bundle for cic_interp_mc.
interface cic_interp_mc_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int CHANNELS  = 2,
  parameter int STAGES    = 5,
  parameter int DELAY     = 1,
  parameter int MAX_RATE  = 512
);
  localparam int ACC_W = cic_interp_pkg::acc_width(IN_WIDTH, STAGES, MAX_RATE, DELAY);
  localparam int RW    = cic_interp_pkg::rate_width(MAX_RATE);
  localparam int SW    = cic_interp_pkg::shift_width(ACC_W);

  logic                          i_cfg_load;
  logic [RW-1:0]                 i_rate;
  logic [SW-1:0]                 i_shift;
  logic [CHANNELS*IN_WIDTH-1:0]  i_data;
  logic                          i_valid;
  logic                          o_ready;
  logic [CHANNELS*OUT_WIDTH-1:0] o_data;
  logic                          o_valid;
  logic                          i_ready;

  modport master (
    output i_cfg_load, i_rate, i_shift, i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid
  );

  modport slave (
    input  i_cfg_load, i_rate, i_shift, i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid
  );
endinterface

// File: rtl/cic_interp_lane.sv
// One CIC channel: comb chain on accepted inputs, hold register, integrator
// chain stepped at output rate, scaled/saturated output register.
// CIC_INTERP_ROUND_EN adds round-half-up before the output shift.
module cic_interp_lane import cic_interp_pkg::*; #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int STAGES    = 5,
  parameter int DELAY     = 1,
  parameter int ACC_W     = 61,
  parameter int SW        = 6
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic                        clr,
  input  logic                        accept,
  input  logic                        step,
  input  logic                        ph_zero,
  input  logic [SW-1:0]               shift,
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout
);
  typedef logic signed [ACC_W-1:0] acc_t;

  acc_t dly_q [STAGES][DELAY];
  acc_t dly_d [STAGES][DELAY];
  acc_t int_q [STAGES];
  acc_t int_d [STAGES];
  acc_t hold_q, hold_d;
  logic signed [OUT_WIDTH-1:0] dout_q, dout_d;
  acc_t comb_in [STAGES];
  acc_t comb_out;
  acc_max_t scaled;

  // Comb chain is purely combinational; its delay lines only move on accept.
  always_comb begin
    acc_t x;
    x = acc_t'(din);
    for (int k = 0; k < STAGES; k++) begin
      comb_in[k] = x;
      x = x - dly_q[k][DELAY-1];
    end
    comb_out = x;
  end

  always_comb begin
    scaled = acc_max_t'(int_q[STAGES-1]);
`ifdef CIC_INTERP_ROUND_EN
    if (shift != '0) scaled = scaled + (acc_max_t'(1) <<< (shift - 1'b1));
`endif
    scaled = scaled >>> shift;
  end

  always_comb begin
    dly_d  = dly_q;
    int_d  = int_q;
    hold_d = hold_q;
    dout_d = dout_q;
    if (clr) begin
      for (int k = 0; k < STAGES; k++) begin
        int_d[k] = '0;
        for (int j = 0; j < DELAY; j++) dly_d[k][j] = '0;
      end
      hold_d = '0;
      dout_d = '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < STAGES; k++) begin
          dly_d[k][0] = comb_in[k];
          for (int j = 1; j < DELAY; j++) dly_d[k][j] = dly_q[k][j-1];
        end
        hold_d = comb_out;
      end
      // Pipelined integrators: each stage adds the previous stage's old value.
      if (step) begin
        int_d[0] = int_q[0] + (ph_zero ? hold_q : acc_t'(0));
        for (int k = 1; k < STAGES; k++) int_d[k] = int_q[k] + int_q[k-1];
        dout_d = OUT_WIDTH'(sat(scaled, OUT_WIDTH));
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        int_q[k] <= '0;
        for (int j = 0; j < DELAY; j++) dly_q[k][j] <= '0;
      end
      hold_q <= '0;
      dout_q <= '0;
    end else begin
      dly_q  <= dly_d;
      int_q  <= int_d;
      hold_q <= hold_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/cic_interp_mc.sv
// Multi-channel CIC interpolator top: handshake, hold flag, phase counter and
// config registers; per-channel datapath lives in cic_interp_lane.
// Optional rounding at the output shift via CIC_INTERP_ROUND_EN.
module cic_interp_mc import cic_interp_pkg::*; #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int CHANNELS  = 2,
  parameter int STAGES    = 5,
  parameter int DELAY     = 1,
  parameter int MAX_RATE  = 512
) (
  input  logic            i_clock,
  input  logic            i_reset_n,
  cic_interp_mc_if.slave  bus
);
  localparam int ACC_W = acc_width(IN_WIDTH, STAGES, MAX_RATE, DELAY);
  localparam int RW    = rate_width(MAX_RATE);
  localparam int SW    = shift_width(ACC_W);

  logic [RW-1:0] rate_q, rate_d, ph_q, ph_d, rate_cl;
  logic [SW-1:0] shift_q, shift_d;
  logic          hold_full_q, hold_full_d;
  logic          o_valid_q, o_valid_d;
  logic          accept, step, ph_zero;

  logic [CHANNELS-1:0][IN_WIDTH-1:0]  lane_in;
  logic [CHANNELS-1:0][OUT_WIDTH-1:0] lane_out;

  assign ph_zero = (ph_q == '0);
  assign accept  = ~bus.i_cfg_load & bus.i_valid & ~hold_full_q;
  // Zero-stuffed phases step freely; phase 0 needs a held sample.
  assign step    = ~bus.i_cfg_load & (~o_valid_q | bus.i_ready) & (~ph_zero | hold_full_q);
  assign rate_cl = (bus.i_rate == '0) ? RW'(1) :
                   (bus.i_rate > RW'(MAX_RATE)) ? RW'(MAX_RATE) : bus.i_rate;

  always_comb begin
    rate_d      = rate_q;
    shift_d     = shift_q;
    ph_d        = ph_q;
    hold_full_d = hold_full_q;
    o_valid_d   = o_valid_q;
    if (bus.i_cfg_load) begin
      rate_d      = rate_cl;
      shift_d     = bus.i_shift;
      ph_d        = '0;
      hold_full_d = 1'b0;
      o_valid_d   = 1'b0;
    end else begin
      if (accept) hold_full_d = 1'b1;
      else if (step && ph_zero) hold_full_d = 1'b0;
      if (step) begin
        ph_d      = (ph_q == rate_q - 1'b1) ? '0 : ph_q + 1'b1;
        o_valid_d = 1'b1;
      end else if (o_valid_q && bus.i_ready) begin
        o_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rate_q      <= RW'(1);
      shift_q     <= '0;
      ph_q        <= '0;
      hold_full_q <= 1'b0;
      o_valid_q   <= 1'b0;
    end else begin
      rate_q      <= rate_d;
      shift_q     <= shift_d;
      ph_q        <= ph_d;
      hold_full_q <= hold_full_d;
      o_valid_q   <= o_valid_d;
    end
  end

  assign lane_in = bus.i_data;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    cic_interp_lane #(
      .IN_WIDTH (IN_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .STAGES   (STAGES),
      .DELAY    (DELAY),
      .ACC_W    (ACC_W),
      .SW       (SW)
    ) u_lane (
      .i_clock  (i_clock),
      .i_reset_n(i_reset_n),
      .clr      (bus.i_cfg_load),
      .accept   (accept),
      .step     (step),
      .ph_zero  (ph_zero),
      .shift    (shift_q),
      .din      (lane_in[c]),
      .dout     (lane_out[c])
    );
  end

  assign bus.o_data  = lane_out;
  assign bus.o_valid = o_valid_q;
  assign bus.o_ready = ~hold_full_q;

endmodule

// File: tb/tb_cic_interp_mc.sv
// Bench for cic_interp_mc (N=3, M=1): output beats are checked against a
// convolution model built from the boxcar^N impulse response of the CIC.
module tb_cic_interp_mc;
  localparam int NS = 3, MD = 1, CH = 2, IW = 16, OW = 16, RW = 10, SW = 6;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  cic_interp_mc_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CHANNELS(CH), .STAGES(NS),
                     .DELAY(MD), .MAX_RATE(512)) bus();
  cic_interp_mc #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CHANNELS(CH), .STAGES(NS),
                  .DELAY(MD), .MAX_RATE(512)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .bus(bus));

  int n_cmp = 0, n_bad = 0;
  logic [CH*IW-1:0] xq[$];
  logic [CH*IW-1:0] stim[$];
  longint h[$];
  longint log0[$], log1[$];
  int mr = 1, msh = 0, beat_n = 0;
  bit stall_prev = 1'b0;
  logic [CH*OW-1:0] stall_data;
  longint g0, g1;
  int imp[14] = '{0, 0, 0, 1, 3, 6, 10, 12, 12, 10, 6, 3, 1, 0};

  task automatic chk(string nm, longint got, longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic longint sx(logic [15:0] v);
    return longint'(signed'(v));
  endfunction

  function automatic logic [31:0] pk(int a, int b);
    return {16'(b), 16'(a)};
  endfunction

  function automatic int clamp_r(int r);
    return (r == 0) ? 1 : (r > 512) ? 512 : r;
  endfunction

  // Impulse response = boxcar of length R*M convolved with itself N times.
  function automatic void build_h(int r);
    longint t[$];
    int L = r * MD;
    h.delete();
    h.push_back(1);
    repeat (NS) begin
      t = h;
      h.delete();
      for (int i = 0; i < t.size() + L - 1; i++) begin
        longint s = 0;
        for (int k = 0; k < L; k++)
          if (i - k >= 0 && i - k < t.size()) s += t[i-k];
        h.push_back(s);
      end
    end
  endfunction

  function automatic longint scale_m(longint a, int s);
`ifdef CIC_INTERP_ROUND_EN
    if (s > 0) a += longint'(1) << (s - 1);
`endif
    a = a >>> s;
    if (a > 32767) return 32767;
    if (a < -32768) return -32768;
    return a;
  endfunction

  // Beat n (since flush) = h convolved with the zero-stuffed input, delayed N beats.
  function automatic longint exp_beat(int n, int c);
    longint acc = 0;
    for (int j = 0; j < h.size(); j++) begin
      int m = n - NS - j;
      logic [31:0] w;
      if (m < 0) break;
      if (m % mr == 0 && m / mr < xq.size()) begin
        w = xq[m / mr];
        acc += h[j] * sx(w[c*16 +: 16]);
      end
    end
    return scale_m(acc, msh);
  endfunction

  function automatic void model_reset(int r, int s);
    xq.delete(); log0.delete(); log1.delete();
    beat_n = 0; stall_prev = 1'b0; mr = r; msh = s;
    build_h(r);
  endfunction

  initial forever begin
    @(negedge clk);
    if (!rst_n) model_reset(1, 0);
    else if (bus.i_cfg_load) model_reset(clamp_r(int'(bus.i_rate)), int'(bus.i_shift));
    else begin
      if (stall_prev && bus.o_valid) begin
        chk("stall_ch0", sx(bus.o_data[15:0]), sx(stall_data[15:0]));
        chk("stall_ch1", sx(bus.o_data[31:16]), sx(stall_data[31:16]));
      end
      if (bus.o_valid && bus.i_ready) begin
        g0 = sx(bus.o_data[15:0]);
        g1 = sx(bus.o_data[31:16]);
        chk($sformatf("beat%0d_ch0", beat_n), g0, exp_beat(beat_n, 0));
        chk($sformatf("beat%0d_ch1", beat_n), g1, exp_beat(beat_n, 1));
        log0.push_back(g0);
        log1.push_back(g1);
        beat_n++;
      end
      stall_prev = bus.o_valid && !bus.i_ready;
      stall_data = bus.o_data;
      if (bus.i_valid && bus.o_ready) xq.push_back(bus.i_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(int r, int s);
    bus.i_valid = 1'b0; bus.i_ready = 1'b0;
    bus.i_cfg_load = 1'b1; bus.i_rate = RW'(r); bus.i_shift = SW'(s);
    cyc();
    bus.i_cfg_load = 1'b0;
    chk("cfg_o_valid", longint'(bus.o_valid), 0);
    chk("cfg_o_data", longint'(bus.o_data), 0);
    chk("cfg_o_ready", longint'(bus.o_ready), 1);
  endtask

  task automatic set_stim(int n, int a, int b, bit rnd);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(rnd ? 32'($urandom) : pk(a, b));
  endtask

  // Feed stim with random gaps; if exp_beats>0, drain and check the beat count.
  task automatic run(int pv, int pr, int exp_beats);
    int idx = 0, cnt = 0;
    bit acc;
    while (idx < stim.size() && cnt < 5000) begin
      bus.i_ready = ($urandom_range(99) < pr);
      bus.i_valid = ($urandom_range(99) < pv);
      bus.i_data  = bus.i_valid ? stim[idx] : 32'($urandom);
      acc = bus.i_valid && bus.o_ready;
      cyc();
      if (acc) idx++;
      cnt++;
    end
    bus.i_valid = 1'b0;
    if (exp_beats > 0) begin
      while (log0.size() < exp_beats && cnt < 5000) begin
        bus.i_ready = ($urandom_range(99) < pr);
        cyc();
        cnt++;
      end
      bus.i_ready = 1'b1;
      repeat (8) cyc();
      chk("beat_count", longint'(log0.size()), exp_beats);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    bus.i_cfg_load = 1'b0; bus.i_rate = '0; bus.i_shift = '0;
    bus.i_data = '0; bus.i_valid = 1'b0; bus.i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", longint'(bus.o_valid), 0);
    chk("rst_o_data", longint'(bus.o_data), 0);
    chk("rst_o_ready", longint'(bus.o_ready), 1);
    rst_n = 1'b1;
    cyc();

    // impulse on ch0, R=4
    do_cfg(4, 0);
    set_stim(5, 0, 0, 1'b0);
    stim[0] = pk(1, 0);
    run(100, 100, 20);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("imp_ch0_%0d", i), log0[i], imp[i]);
      chk($sformatf("imp_ch1_%0d", i), log1[i], 0);
    end

    // constant DC, gain R^(N-1)=16
    do_cfg(4, 0);
    set_stim(10, 100, 100, 1'b0);
    run(100, 100, 40);
    chk("dc_s0_ch0", log0[39], 1600);
    chk("dc_s0_ch1", log1[39], 1600);
    do_cfg(4, 4);
    set_stim(10, 100, 100, 1'b0);
    run(100, 100, 40);
    chk("dc_s4_ch0", log0[39], 100);

    // saturation at full-scale inputs
    do_cfg(4, 0);
    set_stim(10, 32767, -32768, 1'b0);
    run(100, 100, 40);
    chk("sat_pos", log0[39], 32767);
    chk("sat_neg", log1[39], -32768);
    chk("sat_pos_mid", log0[20], 32767);

    // shift=1 on accumulator values 1 and 3
    do_cfg(4, 1);
    set_stim(5, 0, 0, 1'b0);
    stim[0] = pk(1, 0);
    run(100, 100, 20);
`ifdef CIC_INTERP_ROUND_EN
    chk("round_acc1", log0[3], 1);
    chk("round_acc3", log0[4], 2);
`else
    chk("trunc_acc1", log0[3], 0);
    chk("trunc_acc3", log0[4], 1);
`endif

    // random data, rates, shifts and handshake gaps
    for (int it = 0; it < 6; it++) begin
      int r, s;
      r = $urandom_range(1, 8);
      s = $urandom_range(0, 7);
      do_cfg(r, s);
      set_stim(12, 0, 0, 1'b1);
      run(60, 60, 12 * r);
    end

    // reconfigure to R=1 mid-stream
    do_cfg(4, 0);
    set_stim(5, 0, 0, 1'b1);
    run(100, 100, 0);
    do_cfg(1, 0);
    set_stim(8, 0, 0, 1'b1);
    run(70, 70, 8);
    for (int i = 0; i < 5; i++) begin
      w = stim[i];
      chk($sformatf("r1_ch0_%0d", i), log0[NS+i], sx(w[15:0]));
    end

    // rate boundaries: 0 acts as 1, over-range clamps to 512
    do_cfg(0, 0);
    set_stim(4, 0, 0, 1'b1);
    run(100, 100, 4);
    do_cfg(1023, 0);
    set_stim(1, 1, -1, 1'b0);
    run(100, 100, 512);

    // async reset mid-stream
    do_cfg(4, 0);
    set_stim(3, 0, 0, 1'b1);
    run(100, 100, 0);
    bus.i_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_o_valid", longint'(bus.o_valid), 0);
    chk("mid_rst_o_data", longint'(bus.o_data), 0);
    chk("mid_rst_o_ready", longint'(bus.o_ready), 1);
    cyc(); cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_o_valid", longint'(bus.o_valid), 0);
    end
    set_stim(3, 0, 0, 1'b1);
    run(100, 100, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
